servo_pulse_decoder: RTL and testbench
======================================

Name: servo_pulse_decoder

Overview:
Receive-side counterpart of the servo PWM generator. Measures an incoming hobby-servo PWM signal (high time and frame period, in microseconds), validates the frame, and converts the pulse width to a commanded angle of 0-180 degrees with a sequential divider. Used for loopback self-test of the servo output path and for reading external RC receivers.

Parameters:
CLK_PER_US, 100, clk_100M cycles per microsecond tick
PW_MIN_US, 1000, pulse width mapped to angle 0
PW_MAX_US, 2000, pulse width mapped to angle 180 (must be > PW_MIN_US)
PERIOD_MIN_US, 18000, shortest accepted frame period
PERIOD_MAX_US, 22000, longest accepted frame period
TIMEOUT_US, 25000, no rising edge for this long -> signal lost

Ports:
clk_100M  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
en  in  1  decoder enable
pwm_in  in  1  asynchronous servo PWM input
angle  out  8  decoded angle, 0-180
pulsewidth_us  out  12  last accepted high time in us
period_us  out  16  last accepted frame period in us
angle_stb  out  1  one-cycle pulse when angle/pulsewidth_us/period_us update
valid  out  1  high while frames are being accepted
frame_err  out  1  one-cycle pulse on a rejected frame
signal_lost  out  1  high after a timeout, until the next accepted frame

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM to WAIT_RISE, counters and synchroniser cleared.
- pwm_in passes through a 2-flop synchroniser plus an edge register; an edge is detected 3 cycles after the pin transition, with equal delay for both edges.
- us prescaler counts 0..CLK_PER_US-1 and is restarted at 0 on every detected rising edge. The us counters increment on prescaler wrap. hi_cnt is 12 bits and per_cnt is 16 bits; both saturate and never wrap.
- Measurement FSM:
  - WAIT_RISE: on rising edge -> MEAS_HIGH, clear hi_cnt and per_cnt.
  - MEAS_HIGH: count both; on falling edge latch hi_cnt -> MEAS_LOW.
  - MEAS_LOW: count per_cnt; on rising edge -> frame end:
    - if PERIOD_MIN_US <= per_cnt <= PERIOD_MAX_US, capture hi/per and start the divider;
    - otherwise pulse frame_err.
    - In both cases clear counters and go to MEAS_HIGH; the new frame starts on the same edge.
- Timeout: per_cnt reaching TIMEOUT_US in any state except WAIT_RISE -> signal_lost=1, valid=0, FSM to WAIT_RISE. A line stuck high or stuck low both time out.
- Divider (CALC, independent of the FSM):
  - Load cycle forms numerator N:
    - pw <= PW_MIN_US -> N = 0;
    - pw >= PW_MAX_US -> N = (PW_MAX_US-PW_MIN_US)*180;
    - else N = (pw-PW_MIN_US)*180, computed with shift-adds (x<<7 + x<<5 + x<<4 + x<<2).
  - Divisor D = PW_MAX_US-PW_MIN_US. Restoring division, one quotient bit per cycle, 18 iterations, floor result.
  - The cycle after the last iteration: angle = quotient, pulsewidth_us/period_us = captured values, angle_stb=1, valid=1, signal_lost=0.
  - Fixed latency: angle_stb is exactly 20 cycles after the capturing rising edge is detected.
  - The period window guarantees CALC finishes before the next capture; no queueing is required.
- en=0: FSM forced to WAIT_RISE, counters cleared, divider aborted with no strobe, valid=0. angle, pulsewidth_us and period_us hold their last values; signal_lost holds. Measurement restarts at the first rising edge after en=1. The first partial frame is never reported.
- The first rising edge after reset or timeout only starts measurement; the first angle_stb follows the second rising edge.
- Simultaneous events:
  - Timeout and edge in the same cycle: timeout wins.
  - en falling during CALC: abort, no strobe.
- Outputs are registered; angle never exceeds 180.

Test Plan:
- 1500 us high / 20000 us period, 3 frames -> first angle_stb 20 cycles after 2nd rising edge detect; angle=90, pulsewidth_us=1500, period_us=20000, valid=1.
- Pulse widths 1000, 1250, 2000 us at 20 ms -> angle 0, 45, 180; 1255 us -> 45 (floor).
- Clamping: 600 us and 2500 us at 20 ms -> angle 0 and 180, pulsewidth_us reports 600 / 2500.
- Period 10000 us and 24000 us -> frame_err pulse per frame, no angle_stb, outputs hold previous values, valid stays 1.
- Line held low 25 ms after valid frames -> signal_lost=1 and valid=0 at per_cnt=25000. Next two good frames -> angle_stb, signal_lost=0.
- rst asserted mid-CALC and en dropped mid-MEAS_HIGH -> all outputs 0 immediately (rst); no strobe and valid=0 (en); correct decode resumes on the 2nd edge.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// Servo PWM receiver: measures high time and frame period in microseconds, validates
// the frame period and converts the pulse width to a 0-180 degree angle.
module servo_pulse_decoder #(
   parameter int CLK_PER_US    = 100,
   parameter int PW_MIN_US     = 1000,
   parameter int PW_MAX_US     = 2000,
   parameter int PERIOD_MIN_US = 18000,
   parameter int PERIOD_MAX_US = 22000,
   parameter int TIMEOUT_US    = 25000
) (
   input  logic        clk_100M,
   input  logic        rst,
   input  logic        en,
   input  logic        pwm_in,
   output logic [7:0]  angle,
   output logic [11:0] pulsewidth_us,
   output logic [15:0] period_us,
   output logic        angle_stb,
   output logic        valid,
   output logic        frame_err,
   output logic        signal_lost
);

   localparam int PS_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam int DIV  = PW_MAX_US - PW_MIN_US;
   localparam int N_W  = 18;
   localparam int ITER = 18;
   localparam int R_W  = $clog2(DIV + 1) + 1;
   localparam logic [N_W-1:0] N_MAX = N_W'(DIV * 180);

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2
   } state_t;

   state_t          state_reg;
   logic            pwm_s1_reg, pwm_s2_reg, pwm_s3_reg;
   logic            rise, fall;
   logic [PS_W-1:0] presc_reg;
   logic            tick;
   logic [11:0]     hi_cnt_reg, hi_inc, cap_hi_reg;
   logic [15:0]     per_cnt_reg, per_inc, cap_per_reg;
   logic            timeout_hit, period_ok, start_reg;

   logic            busy_reg;
   logic [4:0]      iter_reg;
   logic [R_W-1:0]  rem_reg, trial;
   logic            trial_ge;
   logic [N_W-1:0]  quo_reg, num, pw_off;

   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         pwm_s1_reg <= 1'b0;
         pwm_s2_reg <= 1'b0;
         pwm_s3_reg <= 1'b0;
      end else begin
         pwm_s1_reg <= pwm_in;
         pwm_s2_reg <= pwm_s1_reg;
         pwm_s3_reg <= pwm_s2_reg;
      end
   end

   assign rise = pwm_s2_reg & ~pwm_s3_reg;
   assign fall = ~pwm_s2_reg & pwm_s3_reg;
   assign tick = (presc_reg == PS_W'(CLK_PER_US - 1));

   // Saturating next values; counters only advance on a microsecond tick.
   always_comb begin
      hi_inc  = hi_cnt_reg;
      per_inc = per_cnt_reg;
      if (tick) begin
         if (hi_cnt_reg != '1)
            hi_inc = hi_cnt_reg + 12'd1;
         if (per_cnt_reg != '1)
            per_inc = per_cnt_reg + 16'd1;
      end
   end

   assign timeout_hit = en && (state_reg != WAIT_RISE) && (per_inc >= 16'(TIMEOUT_US));
   assign period_ok   = (per_inc >= 16'(PERIOD_MIN_US)) && (per_inc <= 16'(PERIOD_MAX_US));

   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         state_reg   <= WAIT_RISE;
         presc_reg   <= '0;
         hi_cnt_reg  <= '0;
         per_cnt_reg <= '0;
         cap_hi_reg  <= '0;
         cap_per_reg <= '0;
         start_reg   <= 1'b0;
         frame_err   <= 1'b0;
      end else if (!en) begin
         state_reg   <= WAIT_RISE;
         presc_reg   <= '0;
         hi_cnt_reg  <= '0;
         per_cnt_reg <= '0;
         start_reg   <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         start_reg <= 1'b0;
         frame_err <= 1'b0;
         if (rise || tick)
            presc_reg <= '0;
         else
            presc_reg <= presc_reg + PS_W'(1);

         case (state_reg)
            WAIT_RISE: begin
               if (rise) begin
                  hi_cnt_reg  <= '0;
                  per_cnt_reg <= '0;
                  state_reg   <= MEAS_HIGH;
               end
            end
            MEAS_HIGH: begin
               if (timeout_hit) begin
                  hi_cnt_reg  <= '0;
                  per_cnt_reg <= '0;
                  state_reg   <= WAIT_RISE;
               end else begin
                  hi_cnt_reg  <= hi_inc;
                  per_cnt_reg <= per_inc;
                  if (fall)
                     state_reg <= MEAS_LOW;
               end
            end
            MEAS_LOW: begin
               if (timeout_hit) begin
                  hi_cnt_reg  <= '0;
                  per_cnt_reg <= '0;
                  state_reg   <= WAIT_RISE;
               end else if (rise) begin
                  // Frame end and start of the next frame on the same edge.
                  if (period_ok) begin
                     cap_hi_reg  <= hi_cnt_reg;
                     cap_per_reg <= per_inc;
                     start_reg   <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  hi_cnt_reg  <= '0;
                  per_cnt_reg <= '0;
                  state_reg   <= MEAS_HIGH;
               end else begin
                  per_cnt_reg <= per_inc;
               end
            end
            default: state_reg <= WAIT_RISE;
         endcase
      end
   end

   // Numerator (pw - PW_MIN) * 180, clamped to the 0..180 degree range.
   always_comb begin
      num    = '0;
      pw_off = N_W'(cap_hi_reg) - N_W'(PW_MIN_US);
      if (cap_hi_reg <= 12'(PW_MIN_US))
         num = '0;
      else if (cap_hi_reg >= 12'(PW_MAX_US))
         num = N_MAX;
      else
         num = (pw_off << 7) + (pw_off << 5) + (pw_off << 4) + (pw_off << 2);
   end

   assign trial    = {rem_reg[R_W-2:0], quo_reg[N_W-1]};
   assign trial_ge = (trial >= R_W'(DIV));

   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         busy_reg      <= 1'b0;
         iter_reg      <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         angle         <= '0;
         pulsewidth_us <= '0;
         period_us     <= '0;
         angle_stb     <= 1'b0;
         valid         <= 1'b0;
         signal_lost   <= 1'b0;
      end else begin
         angle_stb <= 1'b0;
         if (!en) begin
            busy_reg <= 1'b0;
            valid    <= 1'b0;
         end else begin
            if (start_reg) begin
               quo_reg  <= num;
               rem_reg  <= '0;
               iter_reg <= 5'(ITER);
               busy_reg <= 1'b1;
            end else if (busy_reg) begin
               if (iter_reg != 5'd0) begin
                  rem_reg  <= trial_ge ? (trial - R_W'(DIV)) : trial;
                  quo_reg  <= {quo_reg[N_W-2:0], trial_ge};
                  iter_reg <= iter_reg - 5'd1;
               end else begin
                  busy_reg      <= 1'b0;
                  angle         <= quo_reg[7:0];
                  pulsewidth_us <= cap_hi_reg;
                  period_us     <= cap_per_reg;
                  angle_stb     <= 1'b1;
                  valid         <= 1'b1;
                  signal_lost   <= 1'b0;
               end
            end
            if (timeout_hit) begin
               valid       <= 1'b0;
               signal_lost <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder, run with a scaled time base
// (2 clocks/us, 40..80 us pulse range, 360..440 us window, 500 us timeout).
module tb_servo_pulse_decoder;

   logic        clk_100M = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        pwm_in = 1'b0;
   logic [7:0]  angle;
   logic [11:0] pulsewidth_us;
   logic [15:0] period_us;
   logic        angle_stb, valid, frame_err, signal_lost;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0;
   int stb_cnt = 0, err_cnt = 0, last_stb_cyc = 0;

   typedef struct {
      int          stb_d;
      int          err_d;
      int          lat;
      logic [7:0]  ang;
      logic [11:0] pw;
      logic [15:0] per;
      logic        vld;
      logic        lost;
   } snap_t;

   servo_pulse_decoder #(
      .CLK_PER_US(2), .PW_MIN_US(40), .PW_MAX_US(80),
      .PERIOD_MIN_US(360), .PERIOD_MAX_US(440), .TIMEOUT_US(500)
   ) dut (
      .clk_100M(clk_100M), .rst(rst), .en(en), .pwm_in(pwm_in),
      .angle(angle), .pulsewidth_us(pulsewidth_us), .period_us(period_us),
      .angle_stb(angle_stb), .valid(valid), .frame_err(frame_err),
      .signal_lost(signal_lost)
   );

   always #5 clk_100M = ~clk_100M;
   always @(posedge clk_100M) cyc <= cyc + 1;

   always @(negedge clk_100M) begin
      if (angle_stb === 1'b1) begin
         stb_cnt++;
         last_stb_cyc = cyc;
      end
      if (frame_err === 1'b1)
         err_cnt++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

   // One frame on the pin; the snapshot taken 26 clocks after the rising pin
   // transition reflects the decode of the frame this rising edge closes.
   task automatic run_frame(input int hi, input int per, output snap_t s);
      int st0, er0, rc;
      st0 = stb_cnt;
      er0 = err_cnt;
      rc  = cyc;
      pwm_in = 1'b1;
      for (int i = 1; i <= hi * 2; i++) begin
         @(negedge clk_100M);
         if (i == 26) begin
            s.stb_d = stb_cnt - st0;
            s.err_d = err_cnt - er0;
            s.lat   = last_stb_cyc - rc;
            s.ang   = angle;
            s.pw    = pulsewidth_us;
            s.per   = period_us;
            s.vld   = valid;
            s.lost  = signal_lost;
         end
      end
      pwm_in = 1'b0;
      repeat ((per - hi) * 2) @(negedge clk_100M);
      $display("frame hi=%0d per=%0d: stb=%0d err=%0d angle=%0d pw=%0d per=%0d valid=%0b lost=%0b",
               hi, per, s.stb_d, s.err_d, s.ang, s.pw, s.per, s.vld, s.lost);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_100M);
      n_checks++;
      if ({angle, pulsewidth_us, period_us, angle_stb, valid, frame_err, signal_lost} !== 40'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {angle, pulsewidth_us, period_us, angle_stb, valid, frame_err, signal_lost});
      end
      rst = 1'b1;
      en  = 1'b1;
      repeat (10) @(negedge clk_100M);
   endtask

   task automatic test_basic();
      snap_t s;
      run_frame(60, 400, s);
      n_checks++;
      if (s.stb_d !== 0 || s.vld !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_first_edge: stb=%0d valid=%0b expected stb=0 valid=0", s.stb_d, s.vld);
      end
      for (int k = 0; k < 2; k++) begin
         run_frame(60, 400, s);
         n_checks++;
         if (s.stb_d !== 1 || s.lat !== 23) begin
            n_fail++;
            $display("FAIL basic_latency: stb=%0d lat=%0d expected stb=1 lat=23", s.stb_d, s.lat);
         end
         n_checks++;
         if (s.ang !== 8'd90 || s.pw !== 12'd60 || s.per !== 16'd400 || s.vld !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_values: angle=%0d pw=%0d per=%0d valid=%0b expected 90/60/400/1",
                     s.ang, s.pw, s.per, s.vld);
         end
      end
   endtask

   task automatic test_widths();
      int    hi_tab[4]  = '{40, 50, 80, 51};
      int    ang_tab[4] = '{90, 0, 45, 180};
      int    pw_tab[4]  = '{60, 40, 50, 80};
      snap_t s;
      for (int k = 0; k < 4; k++) begin
         run_frame(hi_tab[k], 400, s);
         n_checks++;
         if (s.stb_d !== 1 || s.lat !== 23 || s.ang !== 8'(ang_tab[k]) || s.pw !== 12'(pw_tab[k])) begin
            n_fail++;
            $display("FAIL width_%0d: stb=%0d lat=%0d angle=%0d pw=%0d expected 1/23/%0d/%0d",
                     pw_tab[k], s.stb_d, s.lat, s.ang, s.pw, ang_tab[k], pw_tab[k]);
         end
      end
   endtask

   task automatic test_clamp();
      snap_t s;
      run_frame(24, 400, s);
      n_checks++;
      if (s.stb_d !== 1 || s.ang !== 8'd49 || s.pw !== 12'd51) begin
         n_fail++;
         $display("FAIL floor_51: stb=%0d angle=%0d pw=%0d expected 1/49/51", s.stb_d, s.ang, s.pw);
      end
      run_frame(100, 400, s);
      n_checks++;
      if (s.stb_d !== 1 || s.ang !== 8'd0 || s.pw !== 12'd24) begin
         n_fail++;
         $display("FAIL clamp_low: stb=%0d angle=%0d pw=%0d expected 1/0/24", s.stb_d, s.ang, s.pw);
      end
   endtask

   task automatic test_bad_period();
      snap_t s;
      run_frame(60, 200, s);
      n_checks++;
      if (s.stb_d !== 1 || s.ang !== 8'd180 || s.pw !== 12'd100 || s.err_d !== 0) begin
         n_fail++;
         $display("FAIL clamp_high: stb=%0d angle=%0d pw=%0d err=%0d expected 1/180/100/0",
                  s.stb_d, s.ang, s.pw, s.err_d);
      end
      for (int k = 0; k < 2; k++) begin
         run_frame(60, (k == 0) ? 480 : 400, s);
         n_checks++;
         if (s.stb_d !== 0 || s.err_d !== 1 || s.vld !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_period_%0d: stb=%0d err=%0d valid=%0b expected 0/1/1",
                     k, s.stb_d, s.err_d, s.vld);
         end
         n_checks++;
         if (s.ang !== 8'd180 || s.pw !== 12'd100 || s.per !== 16'd400) begin
            n_fail++;
            $display("FAIL bad_period_hold_%0d: angle=%0d pw=%0d per=%0d expected 180/100/400",
                     k, s.ang, s.pw, s.per);
         end
      end
   endtask

   task automatic test_timeout();
      snap_t s;
      int    rc, st0;
      rc  = cyc;
      st0 = stb_cnt;
      pwm_in = 1'b1;
      repeat (26) @(negedge clk_100M);
      n_checks++;
      if (stb_cnt - st0 !== 1 || angle !== 8'd90 || period_us !== 16'd400) begin
         n_fail++;
         $display("FAIL timeout_prev_frame: stb=%0d angle=%0d per=%0d expected 1/90/400",
                  stb_cnt - st0, angle, period_us);
      end
      repeat (120 - 26) @(negedge clk_100M);
      pwm_in = 1'b0;
      while (cyc - rc < 1002) @(negedge clk_100M);
      n_checks++;
      if (signal_lost !== 1'b0 || valid !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_early: lost=%0b valid=%0b expected 0/1", signal_lost, valid);
      end
      @(negedge clk_100M);
      n_checks++;
      if (signal_lost !== 1'b1 || valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_hit: lost=%0b valid=%0b expected 1/0", signal_lost, valid);
      end
      $display("timeout: lost=%0b valid=%0b at clock %0d after last rise", signal_lost, valid, cyc - rc);
      repeat (200) @(negedge clk_100M);
      run_frame(60, 400, s);
      n_checks++;
      if (s.stb_d !== 0 || s.lost !== 1'b1 || s.vld !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_first_edge: stb=%0d lost=%0b valid=%0b expected 0/1/0", s.stb_d, s.lost, s.vld);
      end
      run_frame(50, 400, s);
      n_checks++;
      if (s.stb_d !== 1 || s.ang !== 8'd90 || s.lost !== 1'b0 || s.vld !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_recover: stb=%0d angle=%0d lost=%0b valid=%0b expected 1/90/0/1",
                  s.stb_d, s.ang, s.lost, s.vld);
      end
   endtask

   task automatic test_enable();
      snap_t s;
      int    st0;
      st0 = stb_cnt;
      pwm_in = 1'b1;
      repeat (10) @(negedge clk_100M);
      en = 1'b0;
      @(negedge clk_100M);
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL en_valid: valid=%0b expected 0", valid);
      end
      repeat (20) @(negedge clk_100M);
      n_checks++;
      if (stb_cnt - st0 !== 0 || angle !== 8'd90 || pulsewidth_us !== 12'd60 || period_us !== 16'd400) begin
         n_fail++;
         $display("FAIL en_abort_hold: stb=%0d angle=%0d pw=%0d per=%0d expected 0/90/60/400",
                  stb_cnt - st0, angle, pulsewidth_us, period_us);
      end
      repeat (120 - 31) @(negedge clk_100M);
      pwm_in = 1'b0;
      repeat (340) @(negedge clk_100M);
      en = 1'b1;
      repeat (340) @(negedge clk_100M);
      $display("enable: re-enabled, strobes while disabled=%0d", stb_cnt - st0);
      run_frame(80, 400, s);
      n_checks++;
      if (s.stb_d !== 0 || s.vld !== 1'b0) begin
         n_fail++;
         $display("FAIL en_first_edge: stb=%0d valid=%0b expected 0/0", s.stb_d, s.vld);
      end
      run_frame(50, 400, s);
      n_checks++;
      if (s.stb_d !== 1 || s.ang !== 8'd180 || s.pw !== 12'd80 || s.vld !== 1'b1) begin
         n_fail++;
         $display("FAIL en_resume: stb=%0d angle=%0d pw=%0d valid=%0b expected 1/180/80/1",
                  s.stb_d, s.ang, s.pw, s.vld);
      end
   endtask

   task automatic test_reset_mid();
      snap_t s;
      int    st0;
      st0 = stb_cnt;
      pwm_in = 1'b1;
      repeat (12) @(negedge clk_100M);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({angle, pulsewidth_us, period_us, angle_stb, valid, frame_err, signal_lost} !== 40'd0) begin
         n_fail++;
         $display("FAIL reset_mid_calc: got %h expected 0",
                  {angle, pulsewidth_us, period_us, angle_stb, valid, frame_err, signal_lost});
      end
      repeat (120 - 12) @(negedge clk_100M);
      pwm_in = 1'b0;
      repeat (10) @(negedge clk_100M);
      rst = 1'b1;
      repeat (670) @(negedge clk_100M);
      n_checks++;
      if (stb_cnt - st0 !== 0) begin
         n_fail++;
         $display("FAIL reset_no_strobe: stb=%0d expected 0", stb_cnt - st0);
      end
      run_frame(70, 400, s);
      n_checks++;
      if (s.stb_d !== 0 || s.vld !== 1'b0 || s.ang !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_first_edge: stb=%0d valid=%0b angle=%0d expected 0/0/0", s.stb_d, s.vld, s.ang);
      end
      run_frame(60, 400, s);
      n_checks++;
      if (s.stb_d !== 1 || s.ang !== 8'd135 || s.pw !== 12'd70 || s.per !== 16'd400 || s.vld !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_resume: stb=%0d angle=%0d pw=%0d per=%0d valid=%0b expected 1/135/70/400/1",
                  s.stb_d, s.ang, s.pw, s.per, s.vld);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_widths();
      test_clamp();
      test_bad_period();
      test_timeout();
      test_enable();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
